instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have parameter FBUF_DEPTH, default 4, meaning the fetch-buffer entry count (power of two, 2..16).
REQ-002 The block SHALL have parameter RESET_PC, default 0, meaning the first fetch address after reset (`ADDR_WIDTH bits).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port fetch_en, input, 1 bit: allows issue of new memory reads while high.
REQ-006 The block SHALL have port ifu_rd_req, output, 1 bit: memory read request, one word per cycle when high.
REQ-007 The block SHALL have port ifu_rd_addr, output, `ADDR_WIDTH bits: read address, meaningful only while ifu_rd_req is high.
REQ-008 The block SHALL have port ifu_rd_data, input, `DATA_WIDTH bits: read data, valid in the cycle after the request edge and held until the next request.
REQ-009 The block SHALL have port dec_valid, output, 1 bit: head of fetch buffer holds an instruction.
REQ-010 The block SHALL have port dec_ready, input, 1 bit: decode accepts the head entry this cycle.
REQ-011 The block SHALL have port dec_instr, output, `DATA_WIDTH bits: head instruction word.
REQ-012 The block SHALL have port dec_pc, output, `ADDR_WIDTH bits: address the head instruction was fetched from.
REQ-013 The block SHALL have port redirect_valid, input, 1 bit: branch/jump redirect strobe.
REQ-014 The block SHALL have port redirect_pc, input, `ADDR_WIDTH bits: new fetch address, sampled when redirect_valid is high.

Function
REQ-015 The block SHALL hold a fetch PC; each cycle with ifu_rd_req high it SHALL drive ifu_rd_addr = PC and advance PC by 1 (word-addressed), wrapping from all-ones to 0.
REQ-016 The block SHALL assert ifu_rd_req only when fetch_en=1, redirect_valid=0, and (buffer occupancy + in-flight count) < FBUF_DEPTH.
REQ-017 The block SHALL track one in-flight read: a request issued at edge N SHALL have its ifu_rd_data written into the buffer with its address at edge N+1.
REQ-018 Back-to-back requests SHALL sustain one instruction per cycle into the buffer when decode drains at the same rate.
REQ-019 A handshake SHALL occur when dec_valid and dec_ready are both high; the head entry is then popped at that edge.
REQ-020 dec_instr/dec_pc SHALL be stable while dec_valid=1 and dec_ready=0.
REQ-021 Simultaneous capture and pop SHALL leave occupancy unchanged; capture into a full buffer SHALL never occur (guaranteed by REQ-016).
REQ-022 On redirect_valid=1 the block SHALL, at that edge, flush all buffer entries, discard any in-flight read (its data never enters the buffer), and load PC = redirect_pc; dec_valid SHALL be 0 the following cycle.
REQ-023 Redirect SHALL take priority over a simultaneous pop, capture or issue; a pop in the redirect cycle is still a completed handshake.
REQ-024 The first request after redirect SHALL issue in the cycle following the redirect (address redirect_pc) if fetch_en=1.
REQ-025 Deasserting fetch_en SHALL stop new requests only; an already-issued read SHALL still be captured.
REQ-026 Buffer pointers SHALL wrap modulo FBUF_DEPTH; occupancy SHALL be a $clog2(FBUF_DEPTH)+1-bit counter.

Reset
REQ-027 With rst=1 at an edge: PC <= RESET_PC, buffer empty, in-flight cleared; ifu_rd_req=0 and dec_valid=0 from the following cycle.
REQ-028 Reset mid-operation SHALL discard buffer contents and any in-flight data; dec_instr/dec_pc SHALL reset to 0.
REQ-029 The first request after reset release SHALL address RESET_PC.

Structure
REQ-030 Address/word typedefs (memAdx, memWrd) and their width constants SHALL live in shared package ifu_pkg, used by this block and the memory model.
REQ-031 The fetch buffer SHALL be sub-module ifu_fetch_fifo (data+PC per entry, push/pop/flush, count output).

Verification (bench: ADDR_WIDTH=16, DATA_WIDTH=32, memory returns addr ^ 32'hA5A5_A5A5)
REQ-032 Reset release, fetch_en=1, dec_ready=1 -> requests to 0x0000,0x0001,...; dec_instr 0xA5A5A5A5,0xA5A5A5A4,... one per cycle from cycle 2.
REQ-033 dec_ready=0 for 10 cycles -> exactly 4 requests issued, ifu_rd_req low thereafter, head 0x0000 held stable; release -> entries 0..3 in order, fetch resumes at 0x0004.
REQ-034 redirect_valid=1, redirect_pc=0x0100 while a read of 0x0007 is in flight -> 0x0007 never appears on dec_pc; next request 0x0100, next dec_pc 0x0100.
REQ-035 RESET_PC=0xFFFE, free run -> addresses 0xFFFE,0xFFFF,0x0000 with matching dec_pc.
REQ-036 rst=1 with 3 buffered entries and one in flight -> dec_valid=0 next cycle; after release the first dec_pc equals RESET_PC.
REQ-037 fetch_en dropped the cycle after a request to 0x0020 -> 0x0020 still delivered, no further requests.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared instruction-fetch types.
// Holds the memory address and word widths plus their typedefs. The fetch unit and
// the memory model both import this package.
package ifu_pkg;

  localparam int unsigned ADDR_WIDTH = 16;
  localparam int unsigned DATA_WIDTH = 32;

  typedef logic [ADDR_WIDTH-1:0] memAdx;
  typedef logic [DATA_WIDTH-1:0] memWrd;

  // Word-addressed sequential fetch; wraps from all-ones to zero.
  function automatic memAdx next_adx(input memAdx a);
    return a + memAdx'(1);
  endfunction

endpackage

// File: rtl/ifu_fetch_fifo.sv
// Fetch buffer: a circular FIFO whose entries each hold an instruction word and its fetch PC.
// Ports:
//   clk, rst            - clock; synchronous active-high reset
//   push_i              - write an entry at the tail
//   push_data_i         - instruction word to write
//   push_pc_i           - fetch address to write
//   pop_i               - drop the head entry (ignored when empty)
//   flush_i             - empty the buffer; takes priority over push and pop
//   head_valid_o        - buffer not empty
//   head_data_o         - head entry word
//   head_pc_o           - head entry address
//   count_o             - occupancy (0..DEPTH)
module ifu_fetch_fifo
  import ifu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push_i,
  input  logic [DATA_WIDTH-1:0]         push_data_i,
  input  logic [ADDR_WIDTH-1:0]         push_pc_i,
  input  logic                          pop_i,
  input  logic                          flush_i,
  output logic                          head_valid_o,
  output logic [DATA_WIDTH-1:0]         head_data_o,
  output logic [ADDR_WIDTH-1:0]         head_pc_o,
  output logic [$clog2(DEPTH):0]        count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  memWrd          data_q [DEPTH];
  memAdx          pc_q   [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            pop_eff;

  assign pop_eff = pop_i && (count_q != '0);

  always_comb begin
    count_d = count_q + CntW'(push_i) - CntW'(pop_eff);
  end

  // Pointers are PtrW bits wide and DEPTH is a power of two, so they wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      // Storage is cleared so the head outputs read zero after reset.
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        data_q[wr_ptr_q] <= push_data_i;
        pc_q[wr_ptr_q]   <= push_pc_i;
        wr_ptr_q         <= wr_ptr_q + PtrW'(1);
      end
      if (pop_eff) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_d;
    end
  end

  assign head_valid_o = (count_q != '0);
  assign head_data_o  = data_q[rd_ptr_q];
  assign head_pc_o    = pc_q[rd_ptr_q];
  assign count_o      = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit.
// Issues sequential word reads to a one-cycle-latency memory, captures the returned words
// into a fetch buffer, and presents them to decode through a valid/ready handshake.
// A redirect flushes the buffer, drops any in-flight read and restarts fetch at redirect_pc.
// Ports:
//   clk, rst                 - clock; synchronous active-high reset
//   fetch_en                 - allow new reads
//   ifu_rd_req / ifu_rd_addr - memory read request and address
//   ifu_rd_data              - read data, valid the cycle after the request
//   dec_valid / dec_ready    - decode handshake on the buffer head
//   dec_instr / dec_pc       - head instruction word and its fetch address
//   redirect_valid / _pc     - branch/jump redirect
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int unsigned FBUF_DEPTH = 4,
  parameter memAdx       RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_en,
  output logic                  ifu_rd_req,
  output logic [ADDR_WIDTH-1:0] ifu_rd_addr,
  input  logic [DATA_WIDTH-1:0] ifu_rd_data,
  output logic                  dec_valid,
  input  logic                  dec_ready,
  output logic [DATA_WIDTH-1:0] dec_instr,
  output logic [ADDR_WIDTH-1:0] dec_pc,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc
);

  localparam int unsigned CntW = $clog2(FBUF_DEPTH) + 1;
  localparam logic [CntW:0] DepthLim = (CntW+1)'(FBUF_DEPTH);

  memAdx           pc_q, pc_d;
  logic            inflight_q, inflight_d;
  memAdx           inflight_adx_q, inflight_adx_d;
  logic [CntW-1:0] count;
  logic [CntW:0]   pending;
  logic            issue, push, pop;

  // Buffered entries plus the read still in flight must leave room for the new read,
  // which guarantees a capture never targets a full buffer.
  assign pending = {1'b0, count} + (CntW+1)'(inflight_q);
  assign issue   = fetch_en && !redirect_valid && !rst && (pending < DepthLim);
  // A redirect discards the returning data of the in-flight read.
  assign push    = inflight_q && !redirect_valid;
  assign pop     = dec_valid && dec_ready;

  always_comb begin
    pc_d           = pc_q;
    inflight_d     = 1'b0;
    inflight_adx_d = inflight_adx_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (issue) begin
      pc_d           = next_adx(pc_q);
      inflight_d     = 1'b1;
      inflight_adx_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q           <= RESET_PC;
      inflight_q     <= 1'b0;
      inflight_adx_q <= '0;
    end else begin
      pc_q           <= pc_d;
      inflight_q     <= inflight_d;
      inflight_adx_q <= inflight_adx_d;
    end
  end

  ifu_fetch_fifo #(
    .DEPTH (FBUF_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .push_data_i  (ifu_rd_data),
    .push_pc_i    (inflight_adx_q),
    .pop_i        (pop),
    .flush_i      (redirect_valid),
    .head_valid_o (dec_valid),
    .head_data_o  (dec_instr),
    .head_pc_o    (dec_pc),
    .count_o      (count)
  );

  assign ifu_rd_req  = issue;
  assign ifu_rd_addr = pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a cycle table plus hand-written multi-cycle sequences.
// Memory model returns addr ^ 32'hA5A5_A5A5 one cycle after each request.
module tb_instr_fetch_unit;
  import ifu_pkg::*;

  logic  clk = 1'b0;
  logic  rst, fetch_en, dec_ready, redirect_valid;
  memAdx redirect_pc;

  logic  req_a, valid_a, req_b, valid_b;
  memAdx addr_a, pc_a, addr_b, pc_b;
  memWrd rdata_a, instr_a, rdata_b, instr_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .FBUF_DEPTH (4),
    .RESET_PC   (16'h0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .ifu_rd_req     (req_a),
    .ifu_rd_addr    (addr_a),
    .ifu_rd_data    (rdata_a),
    .dec_valid      (valid_a),
    .dec_ready      (dec_ready),
    .dec_instr      (instr_a),
    .dec_pc         (pc_a),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  instr_fetch_unit #(
    .FBUF_DEPTH (4),
    .RESET_PC   (16'hFFFE)
  ) dut_wrap (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .ifu_rd_req     (req_b),
    .ifu_rd_addr    (addr_b),
    .ifu_rd_data    (rdata_b),
    .dec_valid      (valid_b),
    .dec_ready      (dec_ready),
    .dec_instr      (instr_b),
    .dec_pc         (pc_b),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  // Memory models: data is held until the next request.
  always_ff @(posedge clk) if (req_a) rdata_a <= 32'(addr_a) ^ 32'hA5A5_A5A5;
  always_ff @(posedge clk) if (req_b) rdata_b <= 32'(addr_b) ^ 32'hA5A5_A5A5;

  typedef struct {
    logic  fe;
    logic  rdy;
    logic  rv;
    memAdx rpc;
    logic  e_req;
    memAdx e_addr;
    logic  e_valid;
    memAdx e_pc;
    memWrd e_instr;
    logic  chk_pl;   // compare payload even though e_valid is 0
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic fe, logic rdy, logic rv, memAdx rpc, logic e_req,
                              memAdx e_addr, logic e_valid, memAdx e_pc, memWrd e_instr,
                              logic chk_pl);
    vec_t v;
    v.fe = fe; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_pc = e_pc; v.e_instr = e_instr; v.chk_pl = chk_pl;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive inputs on the falling edge, then sample 1 ns later.
  task automatic drive(input logic r, input logic fe, input logic rdy, input logic rv,
                       input memAdx rpc);
    @(negedge clk);
    rst = r; fetch_en = fe; dec_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    int    nreq;
    memAdx first_addr;
    logic  seen;

    rst = 1'b1; fetch_en = 1'b0; dec_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    //             fe rdy rv rpc       req addr      vld pc        instr          pl
    vecs.push_back(mk(1, 1, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 32'h0000_0000, 1));
    vecs.push_back(mk(1, 1, 0, 16'h0000, 1, 16'h0001, 0, 16'h0000, 32'h0000_0000, 0));
    vecs.push_back(mk(1, 1, 0, 16'h0000, 1, 16'h0002, 1, 16'h0000, 32'hA5A5_A5A5, 0));
    vecs.push_back(mk(1, 1, 0, 16'h0000, 1, 16'h0003, 1, 16'h0001, 32'hA5A5_A5A4, 0));
    vecs.push_back(mk(1, 1, 0, 16'h0000, 1, 16'h0004, 1, 16'h0002, 32'hA5A5_A5A7, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 16'h0005, 1, 16'h0003, 32'hA5A5_A5A6, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 16'h0006, 1, 16'h0003, 32'hA5A5_A5A6, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0003, 32'hA5A5_A5A6, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0003, 32'hA5A5_A5A6, 0));
    vecs.push_back(mk(1, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0003, 32'hA5A5_A5A6, 0));
    vecs.push_back(mk(1, 1, 0, 16'h0000, 1, 16'h0007, 1, 16'h0004, 32'hA5A5_A5A1, 0));
    // Redirect while the read of 0x0007 is in flight.
    vecs.push_back(mk(1, 1, 1, 16'h0100, 0, 16'h0000, 1, 16'h0005, 32'hA5A5_A5A0, 0));
    vecs.push_back(mk(1, 1, 0, 16'h0000, 1, 16'h0100, 0, 16'h0000, 32'h0000_0000, 0));
    vecs.push_back(mk(1, 1, 0, 16'h0000, 1, 16'h0101, 0, 16'h0000, 32'h0000_0000, 0));
    vecs.push_back(mk(1, 1, 0, 16'h0000, 1, 16'h0102, 1, 16'h0100, 32'hA5A5_A4A5, 0));
    // fetch_en dropped: outstanding 0x0102 still arrives, nothing new issues.
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0101, 32'hA5A5_A4A4, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0102, 32'hA5A5_A4A7, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 32'h0000_0000, 0));

    do_reset();
    foreach (vecs[i]) begin
      drive(1'b0, vecs[i].fe, vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
      check($sformatf("v%0d req", i), 32'(req_a), 32'(vecs[i].e_req));
      if (vecs[i].e_req) check($sformatf("v%0d addr", i), 32'(addr_a), 32'(vecs[i].e_addr));
      check($sformatf("v%0d valid", i), 32'(valid_a), 32'(vecs[i].e_valid));
      if (vecs[i].e_valid || vecs[i].chk_pl) begin
        check($sformatf("v%0d pc", i), 32'(pc_a), 32'(vecs[i].e_pc));
        check($sformatf("v%0d instr", i), instr_a, vecs[i].e_instr);
      end
    end

    // Address wrap from RESET_PC = 0xFFFE.
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    check("wrap addr0", 32'(addr_b), 32'h0000_FFFE);
    check("wrap req0", 32'(req_b), 32'h1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    check("wrap addr1", 32'(addr_b), 32'h0000_FFFF);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    check("wrap addr2", 32'(addr_b), 32'h0000_0000);
    check("wrap pc0", 32'(pc_b), 32'h0000_FFFE);
    check("wrap instr0", instr_b, 32'hA5A5_5A5B);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    check("wrap pc1", 32'(pc_b), 32'h0000_FFFF);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    check("wrap pc2", 32'(pc_b), 32'h0000_0000);
    check("wrap valid2", 32'(valid_b), 32'h1);

    // Decode stalled for 10 cycles: exactly four reads, head held.
    do_reset();
    nreq = 0;
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
      if (req_a) nreq++;
      if (c >= 2) check("stall head pc", 32'(pc_a), 32'h0);
      if (c >= 2) check("stall head instr", instr_a, 32'hA5A5_A5A5);
    end
    check("stall req count", 32'(nreq), 32'd4);
    check("stall req low", 32'(req_a), 32'h0);
    seen = 1'b0;
    first_addr = '0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
      check("drain valid", 32'(valid_a), 32'h1);
      check("drain pc", 32'(pc_a), 32'(k));
      if (req_a && !seen) begin
        seen = 1'b1;
        first_addr = addr_a;
      end
    end
    check("resume seen", 32'(seen), 32'h1);
    check("resume addr", 32'(first_addr), 32'h0000_0004);

    // Reset with three entries buffered and one read in flight.
    do_reset();
    for (int c = 0; c < 4; c++) drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    check("pre-rst valid", 32'(valid_a), 32'h1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    check("post-rst valid", 32'(valid_a), 32'h0);
    check("post-rst instr", instr_a, 32'h0);
    check("post-rst req addr", 32'(addr_a), 32'h0);
    check("post-rst req", 32'(req_a), 32'h1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    check("post-rst valid1", 32'(valid_a), 32'h0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    check("post-rst first valid", 32'(valid_a), 32'h1);
    check("post-rst first pc", 32'(pc_a), 32'h0);
    check("post-rst first instr", instr_a, 32'hA5A5_A5A5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
